// File: rtl/mole_pattern_gen_if.sv
// Request/response bundle between the game controller and the mole pattern generator.
// The controller holds the master side and the generator holds the slave side.
interface mole_pattern_gen_if;
    logic        game_start;
    logic        change_answer;
    logic        game_end;
    logic [31:0] data_out;
    logic        write_enable;
    logic        busy;
    logic [6:0]  pattern_count;

    modport master (
        output game_start,
        output change_answer,
        output game_end,
        input  data_out,
        input  write_enable,
        input  busy,
        input  pattern_count
    );

    modport slave (
        input  game_start,
        input  change_answer,
        input  game_end,
        output data_out,
        output write_enable,
        output busy,
        output pattern_count
    );
endinterface

// File: rtl/mole_pattern_gen.sv
// Builds 32-bit words of eight hole indices below NUM_HOLES from a free-running Galois LFSR.
// Optional feature MOLE_NO_REPEAT_EN rejects a nibble equal to the previously accepted one.
module mole_pattern_gen #(
    parameter int          NUM_HOLES = 9,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input logic               clk,
    input logic               reset,
    mole_pattern_gen_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        GEN,
        WRITE
    } state_t;

    localparam logic [15:0] RESET_SEED = (SEED == 16'h0000) ? 16'hACE1 : SEED;
    localparam logic [15:0] LFSR_MASK  = 16'hB400;
    localparam logic [4:0]  HOLE_LIMIT = 5'(NUM_HOLES);
    localparam logic [6:0]  COUNT_MAX  = 7'd127;

    state_t      state_q;
    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;
    logic [31:0] shadow_q;
    logic [31:0] shadow_d;
    logic [31:0] dataOut_q;
    logic [2:0]  idx_q;
    logic        writeEn_q;
    logic        busy_q;
    logic [6:0]  count_q;
    logic        pending_q;
    logic        startPrev_q;

    logic [3:0]  cand;
    logic        inRange;
    logic        accept;
    logic        request;

    assign cand    = lfsr_q[3:0];
    assign inRange = ({1'b0, cand} < HOLE_LIMIT);
    assign request = !bus.game_end &&
                     (bus.change_answer || (bus.game_start && !startPrev_q));

    // Galois right-shift: feed the dropped bit back through the tap mask.
    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]};
        if (lfsr_q[0]) begin
            lfsr_d = lfsr_d ^ LFSR_MASK;
        end
    end

    always_comb begin
        shadow_d = shadow_q;
        shadow_d[{idx_q, 2'b00} +: 4] = cand;
    end

`ifdef MOLE_NO_REPEAT_EN
    logic [3:0] prev_q;
    logic       prevValid_q;

    assign accept = inRange && !(prevValid_q && (cand == prev_q));

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q      <= 4'hF;
            prevValid_q <= 1'b0;
        end else if ((state_q == GEN) && accept) begin
            prev_q      <= cand;
            prevValid_q <= 1'b1;
        end
    end
`else
    assign accept = inRange;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            lfsr_q      <= RESET_SEED;
            shadow_q    <= 32'h0;
            dataOut_q   <= 32'h0;
            idx_q       <= 3'd0;
            writeEn_q   <= 1'b0;
            busy_q      <= 1'b0;
            count_q     <= 7'd0;
            pending_q   <= 1'b0;
            startPrev_q <= 1'b0;
        end else begin
            lfsr_q      <= lfsr_d;
            startPrev_q <= bus.game_start;
            writeEn_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (request) begin
                        state_q <= GEN;
                        idx_q   <= 3'd0;
                        busy_q  <= 1'b1;
                    end
                end
                GEN: begin
                    if (bus.game_end) begin
                        pending_q <= 1'b0;
                    end else if (request) begin
                        pending_q <= 1'b1;
                    end
                    if (accept) begin
                        shadow_q <= shadow_d;
                        idx_q    <= idx_q + 3'd1;
                        if (idx_q == 3'd7) begin
                            state_q   <= WRITE;
                            writeEn_q <= 1'b1;
                            dataOut_q <= shadow_d;
                            if (count_q != COUNT_MAX) begin
                                count_q <= count_q + 7'd1;
                            end
                        end
                    end
                end
                WRITE: begin
                    // A request landing on the strobe cycle chains straight into the next word.
                    if (bus.game_end) begin
                        pending_q <= 1'b0;
                        state_q   <= IDLE;
                        busy_q    <= 1'b0;
                    end else if (pending_q || request) begin
                        pending_q <= 1'b0;
                        state_q   <= GEN;
                        idx_q     <= 3'd0;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data_out      = dataOut_q;
    assign bus.write_enable  = writeEn_q;
    assign bus.busy          = busy_q;
    assign bus.pattern_count = count_q;

endmodule

// File: tb/tb_mole_pattern_gen.sv
// Randomized and directed bench for mole_pattern_gen, checked cycle by cycle against a
// transaction-level model that derives each word by walking the LFSR sequence.
module tb_mole_pattern_gen;

`ifdef MOLE_NO_REPEAT_EN
    localparam int NH    = 2;
    localparam bit NOREP = 1'b1;
`else
    localparam int NH    = 9;
    localparam bit NOREP = 1'b0;
`endif
    localparam logic [15:0] SEED = 16'hACE1;

    logic clk;
    logic reset;

    mole_pattern_gen_if bus ();

    mole_pattern_gen #(
        .NUM_HOLES(NH),
        .SEED(SEED)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int vectors;
    int fails;
    int strobes;

    // Model state: words are computed whole when a generation starts.
    int          edgeNo;
    logic [15:0] mLfsr;
    bit          mGsPrev;
    bit          mActive;
    int          mStrobe;
    bit          mPending;
    logic [31:0] mWord;
    bit          mPrevValid;
    logic [3:0]  mPrev;
    logic [31:0] mData;
    int          mCount;
    bit          expWe;
    bit          expBusy;

    bit          lastValid;
    logic [3:0]  lastNib;

    function automatic logic [15:0] lfsrStep(input logic [15:0] x);
        return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h (edge %0d)", tag, obs, exp, edgeNo);
        end
    endtask

    task automatic genWord(input logic [15:0] startL, output logic [31:0] w, output int steps);
        logic [15:0] l;
        int          got;
        l     = startL;
        got   = 0;
        steps = 0;
        w     = 32'h0;
        while (got < 8 && steps < 20000) begin
            steps++;
            if (int'(l[3:0]) < NH && !(NOREP && mPrevValid && l[3:0] == mPrev)) begin
                w[4*got +: 4] = l[3:0];
                got++;
                mPrevValid = 1'b1;
                mPrev      = l[3:0];
            end
            l = lfsrStep(l);
        end
    endtask

    task automatic startWord(input logic [15:0] l);
        int steps;
        genWord(l, mWord, steps);
        mActive = 1'b1;
        mStrobe = edgeNo + steps;
    endtask

    task automatic modelEdge(input bit rst, input bit ca, input bit gs, input bit ge);
        logic [15:0] lNow;
        bit          req;
        edgeNo++;
        if (rst) begin
            mLfsr      = SEED;
            mGsPrev    = 1'b0;
            mActive    = 1'b0;
            mPending   = 1'b0;
            mData      = 32'h0;
            mCount     = 0;
            mPrevValid = 1'b0;
            mPrev      = 4'hF;
            expWe      = 1'b0;
            expBusy    = 1'b0;
            return;
        end
        req     = !ge && (ca || (gs && !mGsPrev));
        mGsPrev = gs;
        lNow    = lfsrStep(mLfsr);
        if (!mActive) begin
            if (req) startWord(lNow);
        end else if (edgeNo <= mStrobe) begin
            if (ge) mPending = 1'b0;
            else if (req) mPending = 1'b1;
        end else begin
            if (ge) begin
                mPending = 1'b0;
                mActive  = 1'b0;
            end else if (mPending || req) begin
                mPending = 1'b0;
                startWord(lNow);
            end else begin
                mActive = 1'b0;
            end
        end
        mLfsr   = lNow;
        expWe   = mActive && (edgeNo == mStrobe);
        expBusy = mActive;
        if (expWe) begin
            mData = mWord;
            if (mCount < 127) mCount++;
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit ca, input bit gs, input bit ge);
        logic [31:0] w;
        reset             = rst;
        bus.change_answer = ca;
        bus.game_start    = gs;
        bus.game_end      = ge;
        @(posedge clk);
        modelEdge(rst, ca, gs, ge);
        @(negedge clk);
        checkOutput("write_enable", {31'b0, bus.write_enable}, {31'b0, expWe});
        checkOutput("busy", {31'b0, bus.busy}, {31'b0, expBusy});
        checkOutput("pattern_count", {25'b0, bus.pattern_count}, 32'(mCount));
        checkOutput("data_out", bus.data_out, mData);
        if (rst) lastValid = 1'b0;
        if (bus.write_enable === 1'b1) begin
            strobes++;
            w = bus.data_out;
            for (int k = 0; k < 8; k++) begin
                checkOutput("nibbleRange", {31'b0, (int'(w[4*k +: 4]) < NH)}, 32'd1);
            end
`ifdef MOLE_NO_REPEAT_EN
            checkOutput("altWord", {31'b0, (w == 32'h01010101 || w == 32'h10101010)}, 32'd1);
            if (lastValid) checkOutput("crossWord", {31'b0, (w[3:0] != lastNib)}, 32'd1);
`endif
            lastValid = 1'b1;
            lastNib   = w[31:28];
        end
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int  base;
        int  bound;
        bit  gs;
        bit  ge;
        clk       = 1'b0;
        reset     = 1'b1;
        vectors   = 0;
        fails     = 0;
        strobes   = 0;
        edgeNo    = 0;
        lastValid = 1'b0;
        lastNib   = 4'h0;
        bus.change_answer = 1'b0;
        bus.game_start    = 1'b0;
        bus.game_end      = 1'b0;

        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a word: no strobe, nothing recorded.
        base = strobes;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        idleCycles(40);
        checkOutput("abortNoStrobe", 32'(strobes - base), 32'd0);
        checkOutput("abortData", bus.data_out, 32'h0);
        checkOutput("abortCount", {25'b0, bus.pattern_count}, 32'd0);

        // Single request.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        idleCycles(150);

        // Pulses at 0, 3 and 9: the third is absorbed by the pending slot.
        base = strobes;
        for (int c = 0; c < 300; c++) begin
            applyStimulus(1'b0, (c == 0 || c == 3 || c == 9), 1'b0, 1'b0);
        end
        checkOutput("pendingStrobes", 32'(strobes - base), 32'd2);

        // game_start held high yields one word.
        base = strobes;
        for (int c = 0; c < 50; c++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        for (int c = 0; c < 200; c++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("startEdgeOnce", 32'(strobes - base), 32'd1);

        // game_end masks requests.
        base = strobes;
        for (int c = 0; c < 30; c++) applyStimulus(1'b0, (c % 3 == 0), (c % 5 == 1), 1'b1);
        checkOutput("gameEndNoStrobe", 32'(strobes - base), 32'd0);
        checkOutput("gameEndIdle", {31'b0, bus.busy}, 32'd0);

        // Random traffic, including game_end windows and rare resets.
        gs = 1'b0;
        ge = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 5) == 0) gs = ~gs;
            if ($urandom_range(0, 19) == 0) ge = ~ge;
            applyStimulus(($urandom_range(0, 499) == 0), ($urandom_range(0, 7) == 0), gs, ge);
        end
        idleCycles(300);

        // Continuous requests until the counter saturates.
        base  = strobes;
        bound = 0;
        while ((strobes - base) < 200 && bound < 60000) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
            bound++;
        end
        checkOutput("saturationReached", {31'b0, ((strobes - base) >= 200)}, 32'd1);
        idleCycles(400);
        checkOutput("countSaturated", {25'b0, bus.pattern_count}, 32'd127);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
